// File: rtl/multicycle_ctrl.sv
// Control FSM for the shared-memory multicycle datapath: fetch, decode and per-opcode
// execute/memory/writeback sequencing, with a request/ready memory handshake and wait timeout.
//
//  state  | meaning
//  FETCH  | read instruction at PC, PC <= PC+4 when memory answers
//  DECODE | decode op/funct, ALUOut <= branch target
//  MEMADR | ALUOut <= rs + imm (load/store address)
//  MEMRD  | data read at ALUOut, wait for mem_ready
//  MEMWB  | rt <= MDR
//  MEMWR  | data write at ALUOut, wait for mem_ready
//  REX    | R-type ALU operation
//  RWB    | rd <= ALUOut
//  BR     | compare rs/rt, conditional PC <= branch target
//  IEX    | immediate ALU operation
//  IWB    | rt <= ALUOut
//  JMP    | PC <= jump target
//  JREG   | PC <= rs
//  JALR   | PC <= rs, rd <= incremented PC
//  HALT   | stopped on undefined opcode or bus timeout
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TCNT_W         = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       byte_en,
  output logic       irwrite,
  output logic       pcwrite,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regwrite,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REX    = 4'd6,
    RWB    = 4'd7,
    BR     = 4'd8,
    IEX    = 4'd9,
    IWB    = 4'd10,
    JMP    = 4'd11,
    JREG   = 4'd12,
    JALR   = 4'd13,
    HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  localparam logic [TCNT_W-1:0] TC_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TCNT_W'(TIMEOUT_CYCLES - 1);

  state_t            cur;
  state_t            nxt;
  logic [TCNT_W-1:0] tcnt;
  logic              waiting;
  logic              expire;
  logic              decode_bad;

  assign state   = cur;
  assign waiting = mem_req & ~mem_ready;
  // The limit is hit on the last permitted wait cycle; a ready in that cycle is not a wait.
  assign expire  = (TIMEOUT_CYCLES != 0) && waiting && (tcnt == TC_LAST);

  always_comb begin
    nxt        = cur;
    decode_bad = 1'b0;
    case (cur)
      FETCH:  if (mem_ready) nxt = DECODE;
      DECODE: begin
        case (op)
          OP_RTYPE: begin
            if (funct == FN_JR)        nxt = JREG;
            else if (funct == FN_JALR) nxt = JALR;
            else                       nxt = REX;
          end
          OP_LW, OP_SW, OP_LB, OP_SB:        nxt = MEMADR;
          OP_BEQ, OP_BNE:                    nxt = BR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: nxt = IEX;
          OP_J:                              nxt = JMP;
          default: begin
            nxt        = HALT;
            decode_bad = 1'b1;
          end
        endcase
      end
      MEMADR: nxt = (op == OP_LW || op == OP_LB) ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) nxt = MEMWB;
      MEMWB:  nxt = FETCH;
      MEMWR:  if (mem_ready) nxt = FETCH;
      REX:    nxt = RWB;
      RWB:    nxt = FETCH;
      BR:     nxt = FETCH;
      IEX:    nxt = IWB;
      IWB:    nxt = FETCH;
      JMP:    nxt = FETCH;
      JREG:   nxt = FETCH;
      JALR:   nxt = FETCH;
      HALT:   nxt = HALT;
      default: nxt = HALT;
    endcase
    if (expire) nxt = HALT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur     <= FETCH;
      tcnt    <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt != cur || mem_ready)
        tcnt <= '0;
      else if (waiting && tcnt != '1)
        tcnt <= tcnt + TCNT_W'(1);
      if (decode_bad) illegal <= 1'b1;
      if (expire)     bus_err <= 1'b1;
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    byte_en  = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    pcsrc    = 2'b00;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    regwrite = 1'b0;
    regdst   = 2'b00;
    memtoreg = 2'b00;
    case (cur)
      FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        byte_en = (op == OP_LB);
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 2'b01;
        byte_en  = (op == OP_LB);
      end
      MEMWR: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
        byte_en  = (op == OP_SB);
      end
      REX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RWB: begin
        regwrite = 1'b1;
        regdst   = 2'b01;
      end
      BR: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        pcwrite = (op == OP_BEQ) ? zero : ~zero;
      end
      IEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = (op == OP_ADDI) ? 2'b00 : 2'b10;
      end
      IWB: regwrite = 1'b1;
      JMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      JREG: begin
        pcsrc   = 2'b11;
        pcwrite = 1'b1;
      end
      JALR: begin
        pcsrc    = 2'b11;
        pcwrite  = 1'b1;
        regwrite = 1'b1;
        regdst   = 2'b01;
        memtoreg = 2'b10;
      end
      default: ;
    endcase
    // Architectural strobes must never fire while reset is asserted.
    if (reset) begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class, memory waits, timeout and reset.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, iord, memwrite, byte_en, irwrite, pcwrite;
  logic [1:0] pcsrc, alusrcb, aluop, regdst, memtoreg;
  logic       alusrca, regwrite, illegal, bus_err;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_ctrl #(.TIMEOUT_CYCLES(16), .TCNT_W(5)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .memwrite(memwrite),
    .byte_en(byte_en), .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .illegal(illegal), .bus_err(bus_err),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    mem_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // From FETCH with zero-wait memory: fetch cycle, then decode cycle.
  task automatic fetch_decode(input logic [5:0] o, input logic [5:0] f);
    op = o; funct = f; mem_ready = 1'b1;
    #1;
    chk("fetch_state", state, 0);
    chk("fetch_irwrite", irwrite, 1);
    chk("fetch_pcwrite", pcwrite, 1);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("decode_state", state, 1);
    chk("decode_alusrcb", alusrcb, 3);
    tick();
  endtask

  initial begin
    op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst_state", state, 0);
    chk("rst_pcwrite", pcwrite, 0);
    chk("rst_irwrite", irwrite, 0);
    chk("rst_mem_req", mem_req, 1);
    chk("rst_alusrcb", alusrcb, 1);
    chk("rst_illegal", illegal, 0);
    chk("rst_bus_err", bus_err, 0);
    tick();
    reset = 1'b0;

    // ADD: 0,1,6,7,0
    fetch_decode(6'b000000, 6'b100000);
    #1;
    chk("add_rex_state", state, 6);
    chk("add_rex_aluop", aluop, 2);
    chk("add_rex_regwrite", regwrite, 0);
    tick(); #1;
    chk("add_rwb_state", state, 7);
    chk("add_rwb_regwrite", regwrite, 1);
    chk("add_rwb_regdst", regdst, 1);
    tick(); #1;
    chk("add_done_state", state, 0);
    chk("add_done_regwrite", regwrite, 0);

    // LB with 3 wait cycles in MEMRD
    fetch_decode(6'b100000, 6'b000000);
    #1;
    chk("lb_memadr_state", state, 2);
    chk("lb_memadr_alusrcb", alusrcb, 2);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lb_wait_state", state, 3);
      chk("lb_wait_byte_en", byte_en, 1);
      chk("lb_wait_iord", iord, 1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("lb_ready_state", state, 3);
    chk("lb_ready_byte_en", byte_en, 1);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("lb_wb_state", state, 4);
    chk("lb_wb_memtoreg", memtoreg, 1);
    chk("lb_wb_regwrite", regwrite, 1);
    chk("lb_wb_byte_en", byte_en, 1);
    tick(); #1;
    chk("lb_done_state", state, 0);

    // BNE with zero=1: not taken
    zero = 1'b1;
    fetch_decode(6'b000101, 6'b000000);
    #1;
    chk("bne_state", state, 8);
    chk("bne_pcwrite", pcwrite, 0);
    chk("bne_aluop", aluop, 1);
    tick(); #1;
    chk("bne_done_state", state, 0);

    // BEQ with zero=1: taken
    fetch_decode(6'b000100, 6'b000000);
    #1;
    chk("beq_state", state, 8);
    chk("beq_pcwrite", pcwrite, 1);
    chk("beq_pcsrc", pcsrc, 1);
    tick(); #1;
    chk("beq_done_state", state, 0);
    zero = 1'b0;

    // JALR
    fetch_decode(6'b000000, 6'b001001);
    #1;
    chk("jalr_state", state, 13);
    chk("jalr_pcsrc", pcsrc, 3);
    chk("jalr_regwrite", regwrite, 1);
    chk("jalr_memtoreg", memtoreg, 2);
    chk("jalr_regdst", regdst, 1);
    tick();

    // JR
    fetch_decode(6'b000000, 6'b001000);
    #1;
    chk("jr_state", state, 12);
    chk("jr_regwrite", regwrite, 0);
    chk("jr_pcwrite", pcwrite, 1);
    tick();

    // J
    fetch_decode(6'b000010, 6'b000000);
    #1;
    chk("j_state", state, 11);
    chk("j_pcsrc", pcsrc, 2);
    tick();

    // Fetch with 15 wait cycles then ready: completes without error (ADDI)
    op = 6'b001000;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("slow_fetch_irwrite", irwrite, 0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("slow_fetch_state", state, 0);
    chk("slow_fetch_irwrite_rdy", irwrite, 1);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("slow_fetch_decode", state, 1);
    chk("slow_fetch_bus_err", bus_err, 0);
    tick(); #1;
    chk("addi_state", state, 9);
    chk("addi_aluop", aluop, 0);
    tick(); #1;
    chk("addi_iwb_state", state, 10);
    chk("addi_iwb_regwrite", regwrite, 1);
    tick();

    // ORI
    fetch_decode(6'b001101, 6'b000000);
    #1;
    chk("ori_state", state, 9);
    chk("ori_aluop", aluop, 2);
    tick(); tick();

    // Illegal op
    fetch_decode(6'b111111, 6'b000000);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halt_state", state, 15);
      chk("halt_illegal", illegal, 1);
      chk("halt_mem_req", mem_req, 0);
      tick();
    end
    do_reset();
    #1;
    chk("post_halt_illegal", illegal, 0);
    chk("post_halt_state", state, 0);

    // Fetch timeout: 16 wait cycles
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("to_state", state, 0);
      chk("to_irwrite", irwrite, 0);
      tick();
    end
    #1;
    chk("to_halt_state", state, 15);
    chk("to_bus_err", bus_err, 1);
    chk("to_irwrite_after", irwrite, 0);
    do_reset();
    #1;
    chk("post_to_bus_err", bus_err, 0);

    // SW then asynchronous reset in MEMWR
    fetch_decode(6'b101011, 6'b000000);
    #1;
    chk("sw_memadr_state", state, 2);
    tick(); #1;
    chk("sw_memwr_state", state, 5);
    chk("sw_memwrite", memwrite, 1);
    chk("sw_byte_en", byte_en, 0);
    chk("sw_iord", iord, 1);
    reset = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_memwrite", memwrite, 0);
    chk("arst_illegal", illegal, 0);
    chk("arst_bus_err", bus_err, 0);
    tick();
    reset = 1'b0;

    // SB with zero-wait: 4 cycles
    fetch_decode(6'b101000, 6'b000000);
    tick(); mem_ready = 1'b1;
    #1;
    chk("sb_state", state, 5);
    chk("sb_byte_en", byte_en, 1);
    tick(); mem_ready = 1'b0;
    #1;
    chk("sb_done_state", state, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
